// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : shared width encodings and FSM state type for the load/store unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_byte_lane.sv
// ---------------------------------------------------------------------------
// lsu_byte_lane : little-endian byte lane extract (with extension) and merge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_byte_lane (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic        i_sext,
  input  logic [7:0]  i_wbyte,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  logic [7:0] w_byte;
  logic [4:0] w_shift;

  assign w_shift = {i_lane, 3'b000};

  always_comb begin
    w_byte   = i_word[w_shift +: 8];
    o_ext    = {{24{i_sext & w_byte[7]}}, w_byte};
    o_merged = i_word;
    o_merged[w_shift +: 8] = i_wbyte;
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : single-outstanding load/store unit driving a word-only memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wEn,
  output logic [31:0] mem_BusW,
  input  logic [31:0] mem_BusR
);

  import lsu_pkg::*;

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        is_byte_q, is_byte_d;
  logic        sext_q, sext_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_req_bad;
  logic        w_req_byte;
  logic [31:0] w_lane_ext;
  logic [31:0] w_lane_merged;

  lsu_byte_lane u_byte_lane (
    .i_word   (mem_BusR),
    .i_lane   (addr_q[1:0]),
    .i_sext   (sext_q),
    .i_wbyte  (wdata_q[7:0]),
    .o_ext    (w_lane_ext),
    .o_merged (w_lane_merged)
  );

  assign w_req_byte = (req_width == WIDTH_BYTE);
  assign w_req_bad  = ((req_width != WIDTH_BYTE) && (req_width != WIDTH_WORD))
                    || ((req_width == WIDTH_WORD) && (req_addr[1:0] != 2'b00))
                    || (req_addr >= ADDR_LIMIT);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    is_byte_d = is_byte_q;
    sext_d    = sext_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          we_d      = req_we;
          is_byte_d = w_req_byte;
          sext_d    = req_sext;
          rdata_d   = 32'd0;
          err_d     = w_req_bad;
          if (w_req_bad)                  state_d = RESP;
          else if (!req_we || w_req_byte) state_d = RD;
          else                            state_d = WR;
        end
      end
      RD: begin
        // A byte store reuses the write-data register to hold the merged word
        if (we_q) begin
          wdata_d = w_lane_merged;
          state_d = WR;
        end else begin
          rdata_d = is_byte_q ? w_lane_ext : mem_BusR;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      is_byte_q <= 1'b0;
      sext_q    <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      is_byte_q <= is_byte_d;
      sext_q    <= sext_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Ready is gated by rst_n so it stays low while reset is held
  assign req_ready  = (state_q == IDLE) && rst_n;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wEn    = (state_q == WR);
  assign mem_addr   = ((state_q == RD) || (state_q == WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_BusW   = (state_q == WR) ? wdata_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu : directed self-checking bench for lsu against a word-memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wEn;
  logic [31:0] mem_BusW;
  logic [31:0] mem_BusR;

  int tests  = 0;
  int fails  = 0;

  logic [31:0] mem [0:1023];
  int          wen_cnt  = 0;
  int          resp_cnt = 0;
  logic [31:0] wen_addr = 32'd0;

  lsu #(.ADDR_LIMIT(4096)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_sext   (req_sext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wEn    (mem_wEn),
    .mem_BusW   (mem_BusW),
    .mem_BusR   (mem_BusR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_BusR = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_wEn) begin
      mem[mem_addr[11:2]] <= mem_BusW;
      wen_cnt  <= wen_cnt + 1;
      wen_addr <= mem_addr;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // One request; reports latency (negedges after acceptance), response and write pulses
  task automatic do_req(input logic we, input logic [1:0] w, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int wens);
    int  w0;
    bit  got;
    w0  = wen_cnt;
    got = 1'b0;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_sext = sx;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        got = 1'b1;
        rd  = resp_rdata;
        er  = resp_err;
      end
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL pulse_end addr=%h: resp_valid=%b req_ready=%b, required 0/1", a, resp_valid, req_ready);
    end
    wens = wen_cnt - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b11;
    req_sext = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    tests++; if (req_ready  !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
    tests++; if (resp_err   !== 1'b0) begin fails++; $display("FAIL rst_err got=%b exp=0", resp_err); end
    tests++; if (mem_wEn    !== 1'b0) begin fails++; $display("FAIL rst_wen got=%b exp=0", mem_wEn); end
    tests++; if (resp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_BusW !== 32'd0) begin
      fails++; $display("FAIL rst_buses rdata=%h addr=%h busw=%h exp 0", resp_rdata, mem_addr, mem_BusW);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word_store_load();
    int lat, wens; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, wens);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wst_lat got=%0d exp=2", lat); end
    tests++; if (wens !== 1 || wen_addr !== 32'h10) begin fails++; $display("FAIL wst_wen got=%0d@%h exp=1@00000010", wens, wen_addr); end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[4]); end
    tests++; if (rd !== 32'd0 || er !== 1'b0) begin fails++; $display("FAIL wst_resp rdata=%h err=%b exp 0/0", rd, er); end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, wens);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wld_lat got=%0d exp=2", lat); end
    tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL wld_resp rdata=%h err=%b exp deadbeef/0", rd, er); end
    tests++; if (wens !== 0) begin fails++; $display("FAIL wld_wen got=%0d exp=0", wens); end
  endtask

  task automatic test_byte_store();
    int lat, wens; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h11223344, lat, rd, er, wens);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h000000AA, lat, rd, er, wens);
    tests++; if (lat !== 3) begin fails++; $display("FAIL bst_lat got=%0d exp=3", lat); end
    tests++; if (wens !== 1) begin fails++; $display("FAIL bst_wen got=%0d exp=1", wens); end
    tests++; if (mem[8] !== 32'h11AA3344) begin fails++; $display("FAIL bst_mem got=%h exp=11aa3344", mem[8]); end
    tests++; if (rd !== 32'd0 || er !== 1'b0) begin fails++; $display("FAIL bst_resp rdata=%h err=%b exp 0/0", rd, er); end
  endtask

  task automatic test_byte_load();
    int lat, wens; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h80FF0000, lat, rd, er, wens);
    do_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, lat, rd, er, wens);
    tests++; if (rd !== 32'hFFFFFF80 || lat !== 2) begin fails++; $display("FAIL bld_sext3 got=%h lat=%0d exp=ffffff80 lat=2", rd, lat); end
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, lat, rd, er, wens);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL bld_zext3 got=%h exp=00000080", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, rd, er, wens);
    tests++; if (rd !== 32'hFFFFFFFF) begin fails++; $display("FAIL bld_sext2 got=%h exp=ffffffff", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, lat, rd, er, wens);
    tests++; if (rd !== 32'h00000000 || wens !== 0) begin fails++; $display("FAIL bld_sext1 got=%h wens=%0d exp=0 0", rd, wens); end
  endtask

  task automatic test_errors();
    int lat, wens; logic [31:0] rd; logic er;
    logic [1:0]  ew [4];
    logic [31:0] ea [4];
    logic        ewe[4];
    ew[0] = 2'b11; ea[0] = 32'h21;   ewe[0] = 1'b0;
    ew[1] = 2'b10; ea[1] = 32'h20;   ewe[1] = 1'b0;
    ew[2] = 2'b11; ea[2] = 32'h1000; ewe[2] = 1'b0;
    ew[3] = 2'b00; ea[3] = 32'h10;   ewe[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(ewe[i], ew[i], 1'b0, ea[i], 32'hFFFF_FFFF, lat, rd, er, wens);
      tests++;
      if (er !== 1'b1 || rd !== 32'd0 || wens !== 0 || lat !== 1) begin
        fails++;
        $display("FAIL err_case%0d err=%b rdata=%h wens=%0d lat=%0d exp 1/0/0/1", i, er, rd, wens, lat);
      end
    end
    do_req(1'b0, 2'b01, 1'b0, 32'hFFF, 32'h0, lat, rd, er, wens);
    tests++; if (er !== 1'b0 || lat !== 2) begin fails++; $display("FAIL err_edge_ok err=%b lat=%0d exp 0/2", er, lat); end
  endtask

  task automatic test_reset_during_wr();
    int lat, wens, w0, r0; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'h12345678, lat, rd, er, wens);
    w0 = wen_cnt; r0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'b01; req_addr = 32'h31; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (mem_wEn !== 1'b1) begin fails++; $display("FAIL rwr_in_wr wen=%b exp=1", mem_wEn); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (mem_wEn !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rwr_drop wen=%b valid=%b exp 0/0", mem_wEn, resp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rwr_ready got=%b exp=1", req_ready); end
    tests++; if (mem[12] !== 32'h12345678) begin fails++; $display("FAIL rwr_mem got=%h exp=12345678", mem[12]); end
    repeat (3) @(negedge clk);
    tests++; if (wen_cnt !== w0 || resp_cnt !== r0) begin
      fails++; $display("FAIL rwr_nopulse wens=%0d resps=%0d exp 0/0", wen_cnt - w0, resp_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    int acc_cyc [3];
    int n_acc, n_resp, cyc, r0;
    addrs[0] = 32'h10; exps[0] = 32'hDEADBEEF;
    addrs[1] = 32'h20; exps[1] = 32'h80FF0000;
    addrs[2] = 32'h30; exps[2] = 32'h12345678;
    n_acc = 0; n_resp = 0; cyc = 0;
    @(negedge clk);
    r0 = resp_cnt;
    req_we = 1'b0; req_width = 2'b11; req_sext = 1'b0; req_valid = 1'b1;
    while (n_resp < 3 && cyc < 40) begin
      if (resp_valid) begin
        tests++;
        if (resp_rdata !== exps[n_resp]) begin
          fails++; $display("FAIL b2b_data%0d got=%h exp=%h", n_resp, resp_rdata, exps[n_resp]);
        end
        n_resp++;
      end
      if (req_ready) begin
        if (n_acc < 3) begin
          req_addr = addrs[n_acc];
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (n_acc !== 3 || n_resp !== 3 || resp_cnt - r0 !== 3) begin
      fails++; $display("FAIL b2b_count acc=%0d resp=%0d pulses=%0d exp 3/3/3", n_acc, n_resp, resp_cnt - r0);
    end
    tests++; if (n_acc == 3 && (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3)) begin
      fails++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_byte_load();
    test_errors();
    test_reset_during_wr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter ADDR_LIMIT, default 4096, meaning the byte-address bound of the data memory; addresses at or above this bound are errors.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: pipeline request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: request accepted when both req_valid and req_ready are high at a rising edge.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_width, input, 2 bits: 2'b01 = byte, 2'b11 = word, any other value is an error.
REQ-009 The block SHALL have port req_sext, input, 1 bit: sign-extend a byte load.
REQ-010 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data; a byte store uses bits [7:0].
REQ-012 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load result.
REQ-014 The block SHALL have port resp_err, output, 1 bit: the request was rejected.
REQ-015 The block SHALL have port mem_addr, output, 32 bits: word-aligned byte address; bits [1:0] are always 0.
REQ-016 The block SHALL have port mem_wEn, output, 1 bit: word write enable, sampled at the rising edge.
REQ-017 The block SHALL have port mem_BusW, output, 32 bits: word write data.
REQ-018 The block SHALL have port mem_BusR, input, 32 bits: combinational word read data for mem_addr.

Function
REQ-019 The block SHALL be the initiator of a word-only, little-endian memory port: byte lane k of a word is bits [8k+7:8k], selected by addr[1:0] = k.
REQ-020 The block SHALL use the FSM states IDLE, RD, WR, RESP.
REQ-021 req_ready SHALL be high only in IDLE; on acceptance the block SHALL latch the full request.
REQ-022 The block SHALL flag an error when any of these hold: req_width is not 01 or 11; req_width is 11 and addr[1:0] is not 0; req_addr >= ADDR_LIMIT.
REQ-023 On an error the FSM SHALL go IDLE->RESP, with no memory read and no write.
REQ-024 For a load the FSM SHALL go IDLE->RD->RESP; in RD it SHALL drive mem_addr and register mem_BusR at the end of RD.
REQ-025 For a word store the FSM SHALL go IDLE->WR->RESP; in WR it SHALL drive mem_wEn=1 and mem_BusW=req_wdata.
REQ-026 For a byte store the FSM SHALL go IDLE->RD->WR->RESP, a read-modify-write: WR writes the captured word with only the addressed lane replaced by wdata[7:0].
REQ-027 The latency SHALL be fixed, counted from the acceptance edge to the resp_valid cycle: error = 1 cycle; load and word store = 2 cycles; byte store = 3 cycles.
REQ-028 In RESP, resp_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE, and req_ready returns in the following cycle.
REQ-029 The response SHALL be held in registers:
- resp_rdata = word for a word load;
- resp_rdata = addressed byte, zero-extended, or sign-extended from bit 7 when req_sext=1, for a byte load;
- resp_rdata = 0 for stores and errors;
- resp_err = 1 only for errors.
REQ-030 mem_wEn SHALL be high only in WR and SHALL be asserted at most once per request.
REQ-031 Outside RD and WR, mem_addr and mem_BusW SHALL be 0.
REQ-032 req_valid arriving while busy SHALL be ignored until the block returns to IDLE; no request is queued.

Reset
REQ-033 The reset SHALL take effect asynchronously, with all registers cleared and state set to IDLE.
REQ-034 During reset:
- req_ready, resp_valid, resp_err, mem_wEn SHALL be 0;
- resp_rdata, mem_addr, mem_BusW SHALL be 0.
REQ-035 req_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-036 Reset during RD or WR SHALL drop mem_wEn immediately, abort the request, and produce no resp_valid for it.

Structure
REQ-037 The shared package lsu_pkg SHALL hold the width encodings (WIDTH_BYTE = 2'b01, WIDTH_WORD = 2'b11) and the state enumeration.
REQ-038 The block SHALL instantiate one combinational sub-module, lsu_byte_lane, which does lane extract with extension and lane merge.

Verification
REQ-039 The bench SHALL cover these directed scenarios against a word-memory model:
- Word store addr 0x10, data 0xDEADBEEF -> one mem_wEn pulse at 0x10, resp_valid 2 cycles after acceptance; word load at 0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0.
- Word 0x11223344 at 0x20, then byte store 0xAA at 0x22 -> memory at 0x20 = 0x11AA3344; resp at 3 cycles, exactly one mem_wEn.
- Byte loads at 0x23 from word 0x80FF0000 -> req_sext=1 gives 0xFFFFFF80; req_sext=0 gives 0x00000080.
- Errors: word load at 0x21, req_width = 2'b10, and address 0x1000 -> resp_err = 1, resp_rdata = 0, no mem_wEn, resp at 1 cycle.
- rst_n low during the WR cycle of a byte store to 0x30 -> mem_wEn low immediately, memory at 0x30 unchanged, no resp_valid, req_ready high in the first cycle after release.
- req_valid held high for back-to-back loads -> each request is accepted only in IDLE; 3 cycles per load including the IDLE cycle; no request is lost or duplicated.
